// File: rtl/parity_pkg.sv
// Shared constants and types for the streaming parity generator/checker.
// Parity mode encodings and the frame-tracking state enumeration.
// No logic; imported by the top and by the testbench.
package parity_pkg;

   localparam logic MODE_EVEN = 1'b0;
   localparam logic MODE_ODD  = 1'b1;

   typedef enum logic {
      IDLE     = 1'b0,
      IN_FRAME = 1'b1
   } frame_state_t;

endpackage

// File: rtl/parity_reduce.sv
// Balanced XOR reduction tree over W bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake at this level.
module parity_reduce #(
   parameter int W = 8
) (
   input  logic [W-1:0] in,
   output logic         p
);

   generate
      if (W == 1) begin : g_leaf
         assign p = in[0];
      end else begin : g_split
         localparam int WL = W / 2;
         localparam int WH = W - WL;
         logic p_lo;
         logic p_hi;

         parity_reduce #(.W(WL)) u_lo (.in(in[WL-1:0]), .p(p_lo));
         parity_reduce #(.W(WH)) u_hi (.in(in[W-1:WL]), .p(p_hi));

         assign p = p_lo ^ p_hi;
      end
   endgenerate

endmodule

// File: rtl/parity_stream_gen_chk.sv
// Streaming per-beat parity generator/checker with running frame parity and error counter.
// Latency: one register stage; a beat accepted in cycle N is presented in cycle N+1.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while stalled.
module parity_stream_gen_chk
   import parity_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16,
   parameter int CHK_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              odd_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_par,
   output logic              out_err,
   output logic              out_last,
   output logic              frame_par,
   output logic [CNT_W-1:0]  err_cnt,
   input  logic              clr_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   frame_state_t state;
   frame_state_t state_nxt;
   logic         facc;
   logic         facc_nxt;
   logic         frame_par_raw;
   logic         accept;
   logic         beat_xor;
   logic         beat_par;
   logic         mismatch;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // The single reduction tree feeds both beat parity and frame parity.
   parity_reduce #(.W(DATA_W)) u_reduce (
      .in (in_data),
      .p  (beat_xor)
   );

   assign beat_par = beat_xor ^ odd_mode;
   assign mismatch = (CHK_EN != 0) && (in_par != beat_par);

   // Frame tracking: the accumulator only carries data bits; the mode bit joins on the last beat.
   always_comb begin
      state_nxt     = state;
      facc_nxt      = facc;
      frame_par_raw = ((state == IN_FRAME) ? facc : 1'b0) ^ beat_xor ^ (in_last & odd_mode);
      if (accept) begin
         facc_nxt = in_last ? 1'b0 : frame_par_raw;
         case (state)
            IDLE:     if (!in_last) state_nxt = IN_FRAME;
            IN_FRAME: if (in_last)  state_nxt = IDLE;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   // Frame state and accumulator registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         facc  <= 1'b0;
      end else begin
         state <= state_nxt;
         facc  <= facc_nxt;
      end
   end

   // Output stage: load on accept, drop valid once drained, hold everything while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_par   <= 1'b0;
         out_err   <= 1'b0;
         out_last  <= 1'b0;
         frame_par <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_par   <= beat_par;
         out_err   <= mismatch;
         out_last  <= in_last;
         frame_par <= frame_par_raw;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating mismatch counter; a clear wins over a simultaneous error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= '0;
      end else if (accept && mismatch && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_parity_stream_gen_chk.sv
module tb_parity_stream_gen_chk;
   import parity_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        odd_mode;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_par;
   logic        in_last;
   logic        out_ready;
   logic        clr_cnt;

   logic        in_ready, out_valid, out_par, out_err, out_last, frame_par;
   logic [7:0]  out_data;
   logic [15:0] err_cnt;

   logic        in_ready2, out_valid2, out_par2, out_err2, out_last2, frame_par2;
   logic [7:0]  out_data2;
   logic [1:0]  err_cnt2;

   logic        in_ready3, out_valid3, out_par3, out_err3, out_last3, frame_par3;
   logic [7:0]  out_data3;
   logic [15:0] err_cnt3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   parity_stream_gen_chk #(.DATA_W(8), .CNT_W(16), .CHK_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_par(in_par), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_par(out_par), .out_err(out_err),
      .out_last(out_last), .frame_par(frame_par), .err_cnt(err_cnt), .clr_cnt(clr_cnt)
   );

   parity_stream_gen_chk #(.DATA_W(8), .CNT_W(2), .CHK_EN(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .in_par(in_par), .in_last(in_last), .out_valid(out_valid2),
      .out_ready(out_ready), .out_data(out_data2), .out_par(out_par2), .out_err(out_err2),
      .out_last(out_last2), .frame_par(frame_par2), .err_cnt(err_cnt2), .clr_cnt(clr_cnt)
   );

   parity_stream_gen_chk #(.DATA_W(8), .CNT_W(16), .CHK_EN(0)) dut3 (
      .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .in_valid(in_valid), .in_ready(in_ready3),
      .in_data(in_data), .in_par(in_par), .in_last(in_last), .out_valid(out_valid3),
      .out_ready(out_ready), .out_data(out_data3), .out_par(out_par3), .out_err(out_err3),
      .out_last(out_last3), .frame_par(frame_par3), .err_cnt(err_cnt3), .clr_cnt(clr_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input logic [7:0] d, input logic par, input logic last, input logic mode);
      in_valid = 1'b1;
      in_data  = d;
      in_par   = par;
      in_last  = last;
      odd_mode = mode;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
      n_checks++; if ({out_par, out_err, out_last, frame_par} !== 4'b0000) begin n_fail++;
         $display("FAIL reset_flags got %b want 0000", {out_par, out_err, out_last, frame_par}); end
      n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_odd_single();
      set_beat(8'h0F, 1'b1, 1'b1, MODE_ODD);
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h0F) begin n_fail++;
         $display("FAIL odd_single_data got v=%b d=%h want v=1 d=0F", out_valid, out_data); end
      n_checks++; if (out_par !== 1'b1 || out_err !== 1'b0) begin n_fail++;
         $display("FAIL odd_single_par got par=%b err=%b want par=1 err=0", out_par, out_err); end
      n_checks++; if (frame_par !== 1'b1 || out_last !== 1'b1) begin n_fail++;
         $display("FAIL odd_single_frame got fp=%b last=%b want fp=1 last=1", frame_par, out_last); end
      n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL odd_single_cnt got %0d want 0", err_cnt); end
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL odd_single_drain got %b want 0", out_valid); end
   endtask

   task automatic test_mismatch();
      set_beat(8'h01, 1'b0, 1'b1, MODE_EVEN);
      step();
      in_valid = 1'b0;
      n_checks++; if (out_par !== 1'b1 || out_err !== 1'b1) begin n_fail++;
         $display("FAIL mismatch_par got par=%b err=%b want par=1 err=1", out_par, out_err); end
      n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL mismatch_cnt got %0d want 1", err_cnt); end
      n_checks++; if (err_cnt2 !== 2'd1) begin n_fail++; $display("FAIL mismatch_cnt2 got %0d want 1", err_cnt2); end
      n_checks++; if (out_err3 !== 1'b0 || err_cnt3 !== 16'd0 || out_par3 !== 1'b1) begin n_fail++;
         $display("FAIL mismatch_nochk got err=%b cnt=%0d par=%b want 0 0 1", out_err3, err_cnt3, out_par3); end
      step();
   endtask

   task automatic test_frame();
      logic [7:0] d [3];
      logic       p [3];
      d[0] = 8'h01; d[1] = 8'h03; d[2] = 8'h80;
      p[0] = 1'b1;  p[1] = 1'b0;  p[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_beat(d[i], p[i], (i == 2), MODE_EVEN);
         step();
         n_checks++; if (out_last !== (i == 2) || out_data !== d[i]) begin n_fail++;
            $display("FAIL frame_beat%0d got last=%b d=%h want last=%b d=%h", i, out_last, out_data, (i == 2), d[i]); end
      end
      in_valid = 1'b0;
      n_checks++; if (frame_par !== 1'b0) begin n_fail++; $display("FAIL frame_par3 got %b want 0", frame_par); end
      n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL frame_cnt got %0d want 1", err_cnt); end
      step();
      // Two-beat frame: odd on the first beat must not leak into the frame result.
      set_beat(8'h01, 1'b0, 1'b0, MODE_ODD);
      step();
      n_checks++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL modechg_par1 got %b want 0", out_par); end
      set_beat(8'h01, 1'b1, 1'b1, MODE_EVEN);
      step();
      in_valid = 1'b0;
      n_checks++; if (out_par !== 1'b1 || frame_par !== 1'b0) begin n_fail++;
         $display("FAIL modechg_last got par=%b fp=%b want par=1 fp=0", out_par, frame_par); end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      set_beat(8'hA5, 1'b0, 1'b0, MODE_EVEN);
      step();
      set_beat(8'h07, 1'b1, 1'b1, MODE_EVEN);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
         n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_par !== 1'b0 || out_last !== 1'b0) begin n_fail++;
            $display("FAIL bp_hold%0d got v=%b d=%h p=%b l=%b want 1 A5 0 0", i, out_valid, out_data, out_par, out_last); end
         step();
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h07 || out_par !== 1'b1 || out_last !== 1'b1) begin n_fail++;
         $display("FAIL bp_next got v=%b d=%h p=%b l=%b want 1 07 1 1", out_valid, out_data, out_par, out_last); end
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_nodup got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      logic       exp_p;
      for (int i = 0; i < 16; i++) begin
         d     = 8'(i * 37 + 5);
         exp_p = (^d) ^ i[0];
         set_beat(d, exp_p, (i == 15), i[0]);
         step();
         n_checks++; if (out_valid !== 1'b1 || out_data !== d || out_par !== exp_p || out_err !== 1'b0) begin n_fail++;
            $display("FAIL stream%0d got v=%b d=%h p=%b e=%b want 1 %h %b 0", i, out_valid, out_data, out_par, out_err, d, exp_p); end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_saturate();
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      n_checks++; if (err_cnt !== 16'd0 || err_cnt2 !== 2'd0) begin n_fail++;
         $display("FAIL clr_idle got %0d/%0d want 0/0", err_cnt, err_cnt2); end
      for (int k = 1; k <= 5; k++) begin
         set_beat(8'h01, 1'b0, 1'b1, MODE_EVEN);
         step();
         n_checks++; if (err_cnt2 !== 2'((k > 3) ? 3 : k) || err_cnt !== 16'(k)) begin n_fail++;
            $display("FAIL sat%0d got %0d/%0d want %0d/%0d", k, err_cnt2, err_cnt, (k > 3) ? 3 : k, k); end
      end
      clr_cnt = 1'b1;
      step();
      clr_cnt  = 1'b0;
      in_valid = 1'b0;
      n_checks++; if (err_cnt2 !== 2'd0 || err_cnt !== 16'd0 || out_err !== 1'b1) begin n_fail++;
         $display("FAIL clr_prio got %0d/%0d err=%b want 0/0 1", err_cnt2, err_cnt, out_err); end
      step();
   endtask

   task automatic test_reset_mid_frame();
      set_beat(8'h01, 1'b0, 1'b0, MODE_EVEN);
      step();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || err_cnt !== 16'd1) begin n_fail++;
         $display("FAIL midrst_pre got v=%b cnt=%0d want 1 1", out_valid, err_cnt); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || err_cnt !== 16'd0) begin n_fail++;
         $display("FAIL midrst_async got v=%b d=%h cnt=%0d want 0 00 0", out_valid, out_data, err_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      set_beat(8'hFF, 1'b1, 1'b1, MODE_ODD);
      step();
      in_valid = 1'b0;
      n_checks++; if (out_par !== 1'b1 || frame_par !== 1'b1 || out_last !== 1'b1 || out_err !== 1'b0) begin n_fail++;
         $display("FAIL midrst_new got p=%b fp=%b l=%b e=%b want 1 1 1 0", out_par, frame_par, out_last, out_err); end
      step();
   endtask

   initial begin
      rst_n     = 1'b0;
      odd_mode  = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_par    = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;
      test_reset();
      test_odd_single();
      test_mismatch();
      test_frame();
      test_backpressure();
      test_back_to_back();
      test_saturate();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
